// File: rtl/lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit behind the ALU. Turns one load/store request
//            into a single handshaked data-bus transaction. It builds byte
//            enables, replicates store data across lanes, and sign/zero-extends
//            load data. The core is stalled while the access is in flight.
//            A one-cycle done pulse returns the result.
// Config   : define MISALIGN_TRAP_EN to trap misaligned H/W accesses
//            (misalign=1, no bus access). When it is undefined, the offending
//            low address bits are ignored and misalign is tied 0.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i_req_valid      - memory instruction present this cycle
//            o_req_ready      - unit idle, request can be accepted
//            i_mem_we         - 1 = store, 0 = load
//            i_mem_op[2:0]    - funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//            i_addr[31:0]     - effective address (ALU C)
//            i_wdata[31:0]    - store data (rs2)
//            o_stall          - hold PC and pipeline registers
//            o_done           - one-cycle completion pulse
//            o_rdata[31:0]    - extended load data, valid with done
//            o_err            - aborted (timeout / illegal op), valid with done
//            o_misalign       - misaligned access trapped, valid with done
//            o_bus_req/o_bus_we/o_bus_addr/o_bus_be/o_bus_wdata - bus request
//            i_bus_ack        - slave completion, read data valid same cycle
//            i_bus_rdata      - read data
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_mem_we,
  input  logic [2:0]  i_mem_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_misalign,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value seen in the last BUS cycle before the access is abandoned.
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_we;
  logic [2:0]  r_op;
  logic [1:0]  r_lo;
  logic [7:0]  r_cnt;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_misalign;

  logic        w_illegal;
  logic        w_mis_trap;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // 011 and 11x are unused encodings; stores have no unsigned variants.
  assign w_illegal = (i_mem_op == 3'b011) || (i_mem_op[2:1] == 2'b11) ||
                     (i_mem_we && i_mem_op[2]);

`ifdef MISALIGN_TRAP_EN
  assign w_mis_trap = ((i_mem_op[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_mem_op[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
  assign w_mis_trap = 1'b0;
`endif

  // Lane enables and replicated store data. H looks only at addr[1] and W is
  // always the full word, so untrapped misaligned accesses fall onto a legal lane.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_wdata;
    case (i_mem_op[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
      end
    endcase
  end

  // Load lane select uses the address bits latched at acceptance.
  assign w_byte = i_bus_rdata[{r_lo, 3'b000} +: 8];
  assign w_half = r_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

  always_comb begin
    w_ext = i_bus_rdata;
    case (r_op)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = i_bus_rdata;
    endcase
  end

  assign w_timeout = (r_cnt == c_TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_next = (w_illegal || w_mis_trap) ? S_DONE : S_BUS;
        end
      end
      S_BUS: begin
        if (i_bus_ack || w_timeout) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_op        <= 3'd0;
      r_lo        <= 2'd0;
      r_cnt       <= 8'd0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we        <= i_mem_we;
            r_op        <= i_mem_op;
            r_lo        <= i_addr[1:0];
            r_bus_we    <= i_mem_we;
            r_bus_addr  <= {i_addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_cnt       <= 8'd0;
            r_rdata     <= 32'd0;
            // Trapped accesses carry their status straight into DONE.
            r_err       <= w_illegal;
            r_misalign  <= w_mis_trap && !w_illegal;
          end
        end
        S_BUS: begin
          r_cnt <= r_cnt + 8'd1;
          // Ack takes priority over a timeout landing in the same cycle.
          if (i_bus_ack) begin
            r_rdata <= r_we ? 32'd0 : w_ext;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_stall     = ((r_state == S_IDLE) && i_req_valid) || (r_state == S_BUS);
  assign o_done      = (r_state == S_DONE);
  assign o_bus_req   = (r_state == S_BUS);
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_be    = r_bus_be;
  assign o_bus_wdata = r_bus_wdata;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu. Expected results ({rdata,err,
//            misalign}) are queued when a request is driven and popped when
//            done pulses. Bus-side fields and timing are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, mem_we, stall, done, err, misalign;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata, rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_mem_we(mem_we), .i_mem_op(mem_op), .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_done(done), .o_rdata(rdata), .o_err(err), .o_misalign(misalign),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_be(bus_be),
    .o_bus_wdata(bus_wdata), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
  );

  typedef logic [33:0] exp_t;  // {rdata, err, misalign}
  exp_t sb[$];
  int checks = 0;
  int fails  = 0;
  logic [34:0] got, expv;      // {done, rdata, err, misalign}

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle; it is accepted at the next edge.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1; mem_we = we; mem_op = op; addr = a; wdata = d;
    #1;
  endtask

  function automatic exp_t sb_pop();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; mem_we = 1'b0; mem_op = 3'd0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    checks++;
    if ({req_ready, done, bus_req, bus_we, err, misalign} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=100000", {req_ready, done, bus_req, bus_we, err, misalign});
    end
    checks++;
    if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'd0) begin
      fails++;
      $display("FAIL reset_data got=%h exp=0", {rdata, bus_addr, bus_wdata, bus_be});
    end
    req_valid = 1'b1; #1;
    checks++;
    if (stall !== 1'b1) begin fails++; $display("FAIL reset_stall_follow1 got=%b exp=1", stall); end
    req_valid = 1'b0; #1;
    checks++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall_follow0 got=%b exp=0", stall); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    sb.push_back({32'hDEADBEEF, 2'b00});
    checks++;
    if ({stall, req_ready} !== 2'b11) begin fails++; $display("FAIL lw_cycle0 stall,ready got=%b exp=11", {stall, req_ready}); end
    tick(); req_valid = 1'b0;
    checks++;
    if ({bus_req, bus_we, bus_be, bus_addr, stall} !== {2'b10, 4'b1111, 32'h100, 1'b1}) begin
      fails++; $display("FAIL lw_cycle1 got=%h exp=%h", {bus_req, bus_we, bus_be, bus_addr, stall}, {2'b10, 4'b1111, 32'h100, 1'b1});
    end
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    tick(); bus_ack = 1'b0; bus_rdata = '0;
    checks++;
    if ({done, stall, bus_req, req_ready} !== 4'b1000) begin
      fails++; $display("FAIL lw_cycle2 done,stall,req,ready got=%b exp=1000", {done, stall, bus_req, req_ready});
    end
    got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
    checks++;
    if (got !== expv) begin fails++; $display("FAIL lw_result got=%h exp=%h", got, expv); end
    tick();
    checks++;
    if ({done, req_ready} !== 2'b01) begin fails++; $display("FAIL lw_cycle3 done,ready got=%b exp=01", {done, req_ready}); end
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;    // bus read data for loads, store data for stores
    logic [31:0] res;  // expected rdata (loads) or bus_wdata (stores)
  } vec_t;

  task automatic test_loads();
    vec_t t [7];
    t[0] = '{3'b000, 32'h103, 4'b1000, 32'h80123456, 32'hFFFFFF80};
    t[1] = '{3'b100, 32'h103, 4'b1000, 32'h80123456, 32'h00000080};
    t[2] = '{3'b001, 32'h102, 4'b1100, 32'h80123456, 32'hFFFF8012};
    t[3] = '{3'b101, 32'h102, 4'b1100, 32'h80123456, 32'h00008012};
    t[4] = '{3'b000, 32'h101, 4'b0010, 32'h80123456, 32'h00000034};
    t[5] = '{3'b001, 32'h100, 4'b0011, 32'h1234C0DE, 32'hFFFFC0DE};
    t[6] = '{3'b100, 32'h102, 4'b0100, 32'h1234C0DE, 32'h00000034};
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, t[i].op, t[i].a, 32'h0);
      sb.push_back({t[i].res, 2'b00});
      tick(); req_valid = 1'b0;
      checks++;
      if ({bus_req, bus_we, bus_be, bus_addr} !== {2'b10, t[i].be, t[i].a[31:2], 2'b00}) begin
        fails++; $display("FAIL load%0d_bus got=%h exp=%h", i, {bus_req, bus_we, bus_be, bus_addr}, {2'b10, t[i].be, t[i].a[31:2], 2'b00});
      end
      bus_ack = 1'b1; bus_rdata = t[i].d;
      tick(); bus_ack = 1'b0; bus_rdata = '0;
      got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
      checks++;
      if (got !== expv) begin fails++; $display("FAIL load%0d_result got=%h exp=%h", i, got, expv); end
      tick();
    end
  endtask

  task automatic test_stores();
    vec_t t [5];
    t[0] = '{3'b001, 32'h202, 4'b1100, 32'h1234ABCD, 32'hABCDABCD};
    t[1] = '{3'b000, 32'h101, 4'b0010, 32'h000000EF, 32'hEFEFEFEF};
    t[2] = '{3'b010, 32'h304, 4'b1111, 32'h11223344, 32'h11223344};
    t[3] = '{3'b000, 32'h100, 4'b0001, 32'hAAAA0055, 32'h55555555};
    t[4] = '{3'b001, 32'h200, 4'b0011, 32'h0000BEEF, 32'hBEEFBEEF};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, t[i].op, t[i].a, t[i].d);
      sb.push_back({32'h0, 2'b00});
      tick(); req_valid = 1'b0;
      checks++;
      if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {2'b11, t[i].be, t[i].a[31:2], 2'b00, t[i].res}) begin
        fails++; $display("FAIL store%0d_bus got=%h exp=%h", i, {bus_req, bus_we, bus_be, bus_addr, bus_wdata}, {2'b11, t[i].be, t[i].a[31:2], 2'b00, t[i].res});
      end
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      tick(); bus_ack = 1'b0; bus_rdata = '0;
      got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
      checks++;
      if (got !== expv) begin fails++; $display("FAIL store%0d_result got=%h exp=%h", i, got, expv); end
      tick();
    end
  endtask

  task automatic test_misalign();
    vec_t t [2];
    t[0] = '{3'b010, 32'h101, 4'b1111, 32'h80123456, 32'h80123456};
    t[1] = '{3'b001, 32'h103, 4'b1100, 32'h80123456, 32'hFFFF8012};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, t[i].op, t[i].a, 32'h0);
`ifdef MISALIGN_TRAP_EN
      sb.push_back({32'h0, 2'b01});
      tick(); req_valid = 1'b0;
      checks++;
      if (bus_req !== 1'b0) begin fails++; $display("FAIL misalign%0d_busreq got=%b exp=0", i, bus_req); end
`else
      sb.push_back({t[i].res, 2'b00});
      tick(); req_valid = 1'b0;
      checks++;
      if ({bus_req, bus_be, bus_addr} !== {1'b1, t[i].be, 32'h100}) begin
        fails++; $display("FAIL misalign%0d_bus got=%h exp=%h", i, {bus_req, bus_be, bus_addr}, {1'b1, t[i].be, 32'h100});
      end
      bus_ack = 1'b1; bus_rdata = t[i].d;
      tick(); bus_ack = 1'b0; bus_rdata = '0;
`endif
      got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
      checks++;
      if (got !== expv) begin fails++; $display("FAIL misalign%0d_result got=%h exp=%h", i, got, expv); end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [6];
    ops[0] = 4'b0011; ops[1] = 4'b0110; ops[2] = 4'b0111;
    ops[3] = 4'b1100; ops[4] = 4'b1101; ops[5] = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i][3], ops[i][2:0], 32'h400, 32'h12345678);
      sb.push_back({32'h0, 2'b10});
      tick(); req_valid = 1'b0;
      checks++;
      if (bus_req !== 1'b0) begin fails++; $display("FAIL illegal%0d_busreq got=%b exp=0", i, bus_req); end
      got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
      checks++;
      if (got !== expv) begin fails++; $display("FAIL illegal%0d_result got=%h exp=%h", i, got, expv); end
      tick();
    end
  endtask

  task automatic test_timeout();
    issue(1'b0, 3'b010, 32'h500, 32'h0);
    sb.push_back({32'h0, 2'b10});
    tick(); req_valid = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      checks++;
      if ({bus_req, done} !== 2'b10) begin fails++; $display("FAIL timeout_wait%0d req,done got=%b exp=10", i, {bus_req, done}); end
      tick();
    end
    checks++;
    if (bus_req !== 1'b0) begin fails++; $display("FAIL timeout_busreq_drop got=%b exp=0", bus_req); end
    got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
    checks++;
    if (got !== expv) begin fails++; $display("FAIL timeout_result got=%h exp=%h", got, expv); end
    tick();
    // Ack arriving in the very cycle the counter expires must win.
    issue(1'b0, 3'b010, 32'h504, 32'h0);
    sb.push_back({32'h0BADF00D, 2'b00});
    tick(); req_valid = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    checks++;
    if ({bus_req, done} !== 2'b10) begin fails++; $display("FAIL timeout_race_pre req,done got=%b exp=10", {bus_req, done}); end
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    tick(); bus_ack = 1'b0; bus_rdata = '0;
    got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
    checks++;
    if (got !== expv) begin fails++; $display("FAIL timeout_race_result got=%h exp=%h", got, expv); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(1'b0, 3'b010, 32'h600, 32'h0);
    tick(); req_valid = 1'b0;
    tick();
    checks++;
    if (bus_req !== 1'b1) begin fails++; $display("FAIL rstmid_busreq_c2 got=%b exp=1", bus_req); end
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    checks++;
    if ({bus_req, req_ready, done} !== 3'b010) begin
      fails++; $display("FAIL rstmid_after req,ready,done got=%b exp=010", {bus_req, req_ready, done});
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", seen); end
    issue(1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
    sb.push_back({32'h0, 2'b00});
    tick(); req_valid = 1'b0;
    checks++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {2'b11, 4'b1111, 32'h300, 32'hCAFEF00D}) begin
      fails++; $display("FAIL rstmid_sw_bus got=%h exp=%h", {bus_req, bus_we, bus_be, bus_addr, bus_wdata}, {2'b11, 4'b1111, 32'h300, 32'hCAFEF00D});
    end
    bus_ack = 1'b1;
    tick(); bus_ack = 1'b0;
    got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
    checks++;
    if (got !== expv) begin fails++; $display("FAIL rstmid_sw_result got=%h exp=%h", got, expv); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 3'b010, 32'h700, 32'h0);
    sb.push_back({32'h11112222, 2'b00});
    tick(); req_valid = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h11112222;
    tick(); bus_ack = 1'b0; bus_rdata = '0;
    got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
    checks++;
    if (got !== expv) begin fails++; $display("FAIL b2b_first got=%h exp=%h", got, expv); end
    // New request presented during DONE must be ignored until IDLE.
    issue(1'b0, 3'b100, 32'h701, 32'h0);
    checks++;
    if ({req_ready, stall} !== 2'b00) begin fails++; $display("FAIL b2b_in_done ready,stall got=%b exp=00", {req_ready, stall}); end
    tick();
    checks++;
    if ({req_ready, stall, bus_req, done} !== 4'b1100) begin
      fails++; $display("FAIL b2b_idle ready,stall,req,done got=%b exp=1100", {req_ready, stall, bus_req, done});
    end
    sb.push_back({32'h0000009C, 2'b00});
    tick(); req_valid = 1'b0;
    checks++;
    if ({bus_req, bus_be, bus_addr} !== {1'b1, 4'b0010, 32'h700}) begin
      fails++; $display("FAIL b2b_second_bus got=%h exp=%h", {bus_req, bus_be, bus_addr}, {1'b1, 4'b0010, 32'h700});
    end
    bus_ack = 1'b1; bus_rdata = 32'h00009C00;
    tick(); bus_ack = 1'b0; bus_rdata = '0;
    got = {done, rdata, err, misalign}; expv = {1'b1, sb_pop()};
    checks++;
    if (got !== expv) begin fails++; $display("FAIL b2b_second got=%h exp=%h", got, expv); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_misalign();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
